// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, controller state encoding and opcode validity check shared by the ALU and its controller
package alu_pkg;
    localparam int OP_W = 6;

    localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OP_W-1:0] OP_AND = 6'b100100;
    localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SEND   = 3'd4
    } state_t;

    function automatic logic is_valid_op(input logic [OP_W-1:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    endfunction
endpackage

// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: collects A, B, opcode bytes from the UART, runs the ALU and ships the result to the transmitter
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int N_BITS  = 8,
    parameter int N_OP    = 6,
    parameter int ALU_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_BITS-1:0] i_rx_data,
    input  logic              i_rx_done,
    input  logic [N_BITS-1:0] i_alu_res,
    output logic [N_BITS-1:0] o_A,
    output logic [N_BITS-1:0] o_B,
    output logic [N_OP-1:0]   o_OP,
    output logic [N_BITS-1:0] o_tx_data,
    output logic              o_tx_start,
    input  logic              i_tx_done,
    output logic              o_busy,
    output logic              o_err
);
    localparam int CW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT);

    state_t            state_q, state_d;
    logic [N_BITS-1:0] a_q, a_d, b_q, b_d, tx_data_q, tx_data_d;
    logic [N_OP-1:0]   op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tx_start_q, tx_start_d, busy_q, busy_d, err_q, err_d;

    // next-state and registered-output computation; rx bytes are only looked at in the GET states
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        tx_data_d  = tx_data_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        err_d      = 1'b0;
        unique case (state_q)
            ST_GET_A: if (i_rx_done) begin
                a_d     = i_rx_data;
                state_d = ST_GET_B;
            end
            ST_GET_B: if (i_rx_done) begin
                b_d     = i_rx_data;
                state_d = ST_GET_OP;
            end
            ST_GET_OP: if (i_rx_done) begin
                if (is_valid_op(i_rx_data[N_OP-1:0])) begin
                    op_d    = i_rx_data[N_OP-1:0];
                    cnt_d   = '0;
                    state_d = ST_EXEC;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_GET_A;
                end
            end
            ST_EXEC: if (cnt_q == CNT_LAST) begin
                tx_data_d  = i_alu_res;
                tx_start_d = 1'b1;
                state_d    = ST_SEND;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            ST_SEND: if (i_tx_done) state_d = ST_GET_A;
            default: state_d = ST_GET_A;
        endcase
        busy_d = (state_d == ST_EXEC) || (state_d == ST_SEND);
    end

    // state and output registers, cleared asynchronously while reset is low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_GET_A;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign o_A        = a_q;
    assign o_B        = b_q;
    assign o_OP       = op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_err      = err_q;
endmodule

// File: tb/tb_alu_uart_ctrl.sv
// tb_alu_uart_ctrl: directed tests of the ALU/UART sequencer against a registered reference ALU
module tb_alu_uart_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] i_rx_data = '0;
    logic       i_rx_done = 1'b0;
    logic [7:0] i_alu_res = '0;
    logic       i_tx_done = 1'b0;
    logic [7:0] o_A, o_B, o_tx_data;
    logic [5:0] o_OP;
    logic       o_tx_start, o_busy, o_err;
    int         tests = 0;
    int         fails = 0;

    alu_uart_ctrl dut (
        .clock(clock), .reset(reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .i_alu_res(i_alu_res), .o_A(o_A), .o_B(o_B), .o_OP(o_OP), .o_tx_data(o_tx_data),
        .o_tx_start(o_tx_start), .i_tx_done(i_tx_done), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clock = ~clock;

    // reference ALU with one register stage
    always_ff @(posedge clock) begin
        case (o_OP)
            6'b100000: i_alu_res <= o_A + o_B;
            6'b100010: i_alu_res <= o_A - o_B;
            6'b100100: i_alu_res <= o_A & o_B;
            6'b100101: i_alu_res <= o_A | o_B;
            6'b100110: i_alu_res <= o_A ^ o_B;
            6'b000011: i_alu_res <= $signed(o_A) >>> o_B;
            6'b000010: i_alu_res <= o_A >> o_B;
            6'b100111: i_alu_res <= ~(o_A | o_B);
            default:   i_alu_res <= '0;
        endcase
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge clock);
        i_rx_done = 1'b0;
    endtask

    task automatic wait_start(output int cyc);
        cyc = 0;
        while (!o_tx_start && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic finish_tx;
        i_tx_done = 1'b1;
        @(negedge clock);
        i_tx_done = 1'b0;
    endtask

    task automatic run_triple(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input logic [7:0] exp, input string name);
        int cyc;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_start(cyc);
        tests++;
        if (cyc !== 2) begin fails++; $display("FAIL %s latency: got %0d cycles, expected 2", name, cyc); end
        tests++;
        if (o_tx_data !== exp) begin fails++; $display("FAIL %s result: got %h, expected %h", name, o_tx_data, exp); end
        @(negedge clock);
        finish_tx();
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clock);
        tests++;
        if ({o_A, o_B, o_OP, o_tx_data, o_tx_start, o_busy, o_err} !== '0) begin
            fails++; $display("FAIL reset_state: got %h, expected 0", {o_A, o_B, o_OP, o_tx_data, o_tx_start, o_busy, o_err});
        end
        reset = 1'b1;
    endtask

    task automatic test_add;
        int cyc;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        tests++;
        if ({o_A, o_B, o_OP, o_busy, o_tx_start} !== {8'h05, 8'h03, 6'h20, 1'b1, 1'b0}) begin
            fails++; $display("FAIL add_operands: got A=%h B=%h OP=%h busy=%b start=%b, expected 05 03 20 1 0", o_A, o_B, o_OP, o_busy, o_tx_start);
        end
        wait_start(cyc);
        tests++;
        if (cyc !== 2 || o_tx_data !== 8'h08) begin
            fails++; $display("FAIL add_result: got cyc=%0d data=%h, expected 2 08", cyc, o_tx_data);
        end
        finish_tx();
        tests++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
            fails++; $display("FAIL add_done: got busy=%b start=%b, expected 0 0", o_busy, o_tx_start);
        end
    endtask

    task automatic test_sub_nor;
        run_triple(8'h03, 8'h05, 8'h22, 8'hFE, "sub");
        run_triple(8'hF0, 8'h0F, 8'h27, 8'h00, "nor");
    endtask

    task automatic test_invalid;
        int starts = 0;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h3F);
        tests++;
        if (o_err !== 1'b1 || o_busy !== 1'b0 || o_OP !== 6'h27 || o_A !== 8'h05) begin
            fails++; $display("FAIL invalid_err: got err=%b busy=%b OP=%h A=%h, expected 1 0 27 05", o_err, o_busy, o_OP, o_A);
        end
        repeat (4) begin
            @(negedge clock);
            starts += int'(o_tx_start);
        end
        tests++;
        if (o_err !== 1'b0 || starts !== 0) begin
            fails++; $display("FAIL invalid_pulse: got err=%b starts=%0d, expected 0 0", o_err, starts);
        end
        run_triple(8'h01, 8'h01, 8'h20, 8'h02, "after_invalid");
    endtask

    task automatic test_send_hold;
        int cyc;
        int starts;
        int bad = 0;
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h20);
        wait_start(cyc);
        starts = int'(o_tx_start);
        for (int i = 0; i < 10; i++) begin
            i_rx_data = 8'hAA;
            i_rx_done = (i == 2);
            @(negedge clock);
            starts += int'(o_tx_start);
            if (o_tx_data !== 8'h05 || o_A !== 8'h02 || o_busy !== 1'b1) bad++;
        end
        i_rx_done = 1'b0;
        tests++;
        if (starts !== 1) begin fails++; $display("FAIL hold_start_count: got %0d, expected 1", starts); end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL hold_stable: got %0d bad cycles, expected 0", bad); end
        finish_tx();
        send_byte(8'h07);
        tests++;
        if (o_A !== 8'h07 || o_busy !== 1'b0) begin
            fails++; $display("FAIL hold_next_a: got A=%h busy=%b, expected 07 0", o_A, o_busy);
        end
        send_byte(8'h01);
        send_byte(8'h20);
        wait_start(cyc);
        tests++;
        if (o_tx_data !== 8'h08) begin fails++; $display("FAIL hold_next_result: got %h, expected 08", o_tx_data); end
        @(negedge clock);
        finish_tx();
    endtask

    task automatic test_reset_exec;
        int starts = 0;
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h20);
        reset = 1'b0;
        #1;
        tests++;
        if ({o_A, o_B, o_OP, o_tx_data, o_tx_start, o_busy, o_err} !== '0) begin
            fails++; $display("FAIL reset_exec: got %h, expected 0", {o_A, o_B, o_OP, o_tx_data, o_tx_start, o_busy, o_err});
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (5) begin
            @(negedge clock);
            starts += int'(o_tx_start);
        end
        tests++;
        if (starts !== 0 || o_busy !== 1'b0) begin
            fails++; $display("FAIL reset_no_start: got starts=%0d busy=%b, expected 0 0", starts, o_busy);
        end
        send_byte(8'h09);
        tests++;
        if (o_A !== 8'h09) begin fails++; $display("FAIL reset_next_a: got %h, expected 09", o_A); end
        send_byte(8'h01);
        send_byte(8'h20);
        wait_start(starts);
        tests++;
        if (o_tx_data !== 8'h0A) begin fails++; $display("FAIL reset_next_result: got %h, expected 0a", o_tx_data); end
        @(negedge clock);
        finish_tx();
    endtask

    task automatic test_upper_bits;
        run_triple(8'h10, 8'h01, 8'hE0, 8'h11, "upper_bits");
        tests++;
        if (o_OP !== 6'h20) begin fails++; $display("FAIL upper_bits_op: got %h, expected 20", o_OP); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_nor();
        test_invalid();
        test_send_hold();
        test_reset_exec();
        test_upper_bits();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_uart_ctrl.md
Name: alu_uart_ctrl

Overview:
- Sequencer between a byte-stream UART receiver/transmitter pair and the registered ALU.
- Collects three received bytes in order (operand A, operand B, opcode) and drives them onto the ALU inputs.
- Waits out the ALU pipeline latency, captures the result and hands it to the transmitter with a start/done handshake.
- Rejects unsupported opcodes with an error pulse; sits at top level between uart_rx, ALU and uart_tx.

Parameters:
- N_BITS, 8, data width of rx/tx bytes, ALU operands and result.
- N_OP, 6, ALU opcode width; taken from the low N_OP bits of the opcode byte.
- ALU_LAT, 1, ALU result latency in clocks after operands change (ALU is registered: 1).

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- i_rx_data  in  N_BITS  received byte, valid when i_rx_done=1.
- i_rx_done  in  1  one-cycle strobe: new byte on i_rx_data.
- i_alu_res  in  N_BITS  ALU result.
- o_A  out  N_BITS  operand A to ALU.
- o_B  out  N_BITS  operand B to ALU.
- o_OP  out  N_OP  opcode to ALU.
- o_tx_data  out  N_BITS  result byte to transmitter.
- o_tx_start  out  1  one-cycle strobe: start transmitting o_tx_data.
- i_tx_done  in  1  one-cycle strobe: transmitter finished.
- o_busy  out  1  1 in EXEC and SEND (rx bytes ignored).
- o_err  out  1  one-cycle pulse on invalid opcode.

Behaviour:
- Reset (reset=0, async): state=GET_A; o_A, o_B, o_OP, o_tx_data = 0; o_tx_start, o_busy, o_err = 0; latency counter = 0.
- All outputs registered.
- States: GET_A, GET_B, GET_OP, EXEC, SEND.
- GET_A, i_rx_done=1: o_A <= i_rx_data; go to GET_B.
- GET_B, i_rx_done=1: o_B <= i_rx_data; go to GET_OP.
- GET_OP, i_rx_done=1:
  - If i_rx_data[N_OP-1:0] is a valid opcode: o_OP <= that value; counter <= 0; go to EXEC.
  - Otherwise: o_err=1 for exactly one cycle; o_OP unchanged; go to GET_A; o_A/o_B keep their values.
- Valid opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, SRA 000011, SRL 000010, NOR 100111.
  - Opcode byte bits above N_OP are ignored.
- EXEC lasts exactly ALU_LAT+1 cycles (counter 0..ALU_LAT).
  - On the edge ending the last EXEC cycle: o_tx_data <= i_alu_res; o_tx_start=1 for that next cycle; go to SEND.
  - With ALU_LAT=1: opcode strobe at edge k → capture at edge k+2, o_tx_start high in cycle after k+2.
- SEND: o_tx_start high only in the first SEND cycle.
  - o_tx_data held stable until i_tx_done=1, then go to GET_A.
  - No timeout; waits indefinitely.
- o_busy=1 exactly while in EXEC or SEND.
  - i_rx_done in these states is dropped: no register change, no state change.
- o_A, o_B, o_OP hold their values through EXEC, SEND and back to GET_A.
  - They change only when a new byte is accepted for them.
- i_tx_done outside SEND: ignored.
- i_tx_done in the same cycle o_tx_start is asserted: accepted; return to GET_A.
- Reset asserted mid-EXEC or mid-SEND: immediate return to reset values.
  - No o_tx_start is emitted after reset releases.
- Arithmetic: the controller does none; widths pass through unchanged.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (ADD..NOR, 6-bit), reused by the ALU and this controller;
  - state encoding constants (3-bit).
- Opcode validity check as a function in the package.
- No sub-module needed; single FSM plus latency counter ($clog2(ALU_LAT+1) bits, min 1).

Test Plan:
- rx 0x05, 0x03, 0x20 (ADD) with real ALU → o_A=0x05, o_B=0x03, o_OP=0x20; o_tx_start pulse with o_tx_data=0x08 two cycles after opcode strobe; i_tx_done → GET_A, o_busy=0.
- rx 0x03, 0x05, 0x22 (SUB) → o_tx_data=0xFE. Also rx 0xF0, 0x0F, 0x27 (NOR) → 0x00.
- rx 0x05, 0x03, 0x3F → o_err one cycle, no o_tx_start, o_OP unchanged. Next triple 0x01, 0x01, 0x20 → result 0x02.
- During SEND: inject i_rx_done with 0xAA, hold i_tx_done low 10 cycles → o_tx_data stable, o_A unchanged, single o_tx_start. After i_tx_done, rx 0x07 accepted as A.
- Reset low for 1 cycle during EXEC → all outputs 0 immediately. No o_tx_start afterwards; next byte accepted as A.
- Opcode byte 0xE0 (upper bits set, low 6 = ADD) with A=0x10, B=0x01 → treated as ADD, o_tx_data=0x11.
